// File: rtl/wb_port_scheduler.sv
// Issue-time scheduler for the shared integer writeback port: reserves ALU/MUL
// writeback cycles at issue and slots divider completions into free cycles.
module wb_port_scheduler #(
    parameter int MUL_LAT    = 3,
    parameter int ALU_LAT    = 1,
    parameter int BR_W       = 20,
    parameter int STARVE_LIM = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            req_is_mul,
    input  logic [BR_W-1:0] req_br_mask,
    output logic            req_grant,
    input  logic            div_resp_valid,
    output logic            div_resp_ready,
    input  logic            alu_resp_valid,
    input  logic            mul_resp_valid,
    input  logic [BR_W-1:0] brupdate_resolve_mask,
    input  logic [BR_W-1:0] brupdate_mispredict_mask,
    input  logic            flush,
    output logic [1:0]      wb_owner,
    output logic            issue_blocked,
    output logic            collision_err
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_ALU  = 2'd1,
        OWN_MUL  = 2'd2,
        OWN_DIV  = 2'd3
    } owner_e;

    typedef struct packed {
        logic            valid;
        logic            owner;   // 0 ALU, 1 MUL
        logic [BR_W-1:0] mask;
    } slot_t;

    // Slot i holds the writeback that happens i cycles from now.
    slot_t            slots      [MUL_LAT];
    slot_t            slots_next [MUL_LAT];
    slot_t            new_slot;
    logic [MUL_LAT:0] live;
    logic             req_live;
    logic [CNT_W-1:0] starve_cnt;

    always_comb begin
        for (int i = 0; i < MUL_LAT; i++) begin
            live[i] = slots[i].valid && !(|(slots[i].mask & brupdate_mispredict_mask)) && !flush;
        end
        live[MUL_LAT] = 1'b0;
    end

    assign req_live       = req_is_mul ? live[MUL_LAT] : live[ALU_LAT];
    assign issue_blocked  = (starve_cnt == CNT_W'(STARVE_LIM));
    assign req_grant      = req_valid && !issue_blocked && !flush && !req_live;
    assign div_resp_ready = div_resp_valid && !flush && !live[0];

    always_comb begin
        if (live[0]) wb_owner = slots[0].owner ? OWN_MUL : OWN_ALU;
        else if (div_resp_ready) wb_owner = OWN_DIV;
        else wb_owner = OWN_NONE;
    end

    // NOTE: every slot gets a default before the conditional updates, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < MUL_LAT; i++) slots_next[i] = '0;
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            slots_next[i].valid = live[i+1];
            slots_next[i].owner = slots[i+1].owner;
            slots_next[i].mask  = slots[i+1].mask & ~brupdate_resolve_mask;
        end
        new_slot.valid = !(|(req_br_mask & brupdate_mispredict_mask));
        new_slot.owner = req_is_mul;
        new_slot.mask  = req_br_mask & ~brupdate_resolve_mask;
        if (req_grant) begin
            if (req_is_mul) slots_next[MUL_LAT-1] = new_slot;
            else            slots_next[ALU_LAT-1] = new_slot;
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: the slot array is reset because its valid bits gate every output.
            for (int i = 0; i < MUL_LAT; i++) slots[i] <= '0;
            starve_cnt    <= '0;
            collision_err <= 1'b0;
        end else begin
            slots <= slots_next;
            if (div_resp_valid && !div_resp_ready) begin
                if (!issue_blocked) starve_cnt <= starve_cnt + CNT_W'(1);
            end else begin
                starve_cnt <= '0;
            end
            collision_err <= (2'(alu_resp_valid) + 2'(mul_resp_valid) + 2'(div_resp_ready)) > 2'd1;
        end
    end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler (MUL_LAT=3, ALU_LAT=1, STARVE_LIM=4).
module tb_wb_port_scheduler;

    localparam int BR_W = 20;

    logic            clock = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_is_mul;
    logic [BR_W-1:0] req_br_mask;
    logic            req_grant;
    logic            div_resp_valid;
    logic            div_resp_ready;
    logic            alu_resp_valid;
    logic            mul_resp_valid;
    logic [BR_W-1:0] brupdate_resolve_mask;
    logic [BR_W-1:0] brupdate_mispredict_mask;
    logic            flush;
    logic [1:0]      wb_owner;
    logic            issue_blocked;
    logic            collision_err;

    int vectors    = 0;
    int miscompares = 0;

    wb_port_scheduler #(.MUL_LAT(3), .ALU_LAT(1), .BR_W(BR_W), .STARVE_LIM(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_is_mul(req_is_mul), .req_br_mask(req_br_mask),
        .req_grant(req_grant),
        .div_resp_valid(div_resp_valid), .div_resp_ready(div_resp_ready),
        .alu_resp_valid(alu_resp_valid), .mul_resp_valid(mul_resp_valid),
        .brupdate_resolve_mask(brupdate_resolve_mask),
        .brupdate_mispredict_mask(brupdate_mispredict_mask),
        .flush(flush), .wb_owner(wb_owner),
        .issue_blocked(issue_blocked), .collision_err(collision_err)
    );

    always #5 clock = ~clock;

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        req_valid = 0; req_is_mul = 0; req_br_mask = '0;
        div_resp_valid = 0; alu_resp_valid = 0; mul_resp_valid = 0;
        brupdate_resolve_mask = '0; brupdate_mispredict_mask = '0; flush = 0;
    endtask

    task automatic settle(input int n);
        drive_idle();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 0;
        req_valid = 1; div_resp_valid = 1; alu_resp_valid = 1;
        tick(); tick();
        #1;
        vectors++; if (req_grant !== 1'b1) begin miscompares++; $display("FAIL reset_grant: got %b want 1", req_grant); end
        vectors++; if (div_resp_ready !== 1'b1) begin miscompares++; $display("FAIL reset_div_ready: got %b want 1", div_resp_ready); end
        vectors++; if (wb_owner !== 2'd3) begin miscompares++; $display("FAIL reset_owner: got %0d want 3", wb_owner); end
        vectors++; if (issue_blocked !== 1'b0) begin miscompares++; $display("FAIL reset_blocked: got %b want 0", issue_blocked); end
        vectors++; if (collision_err !== 1'b0) begin miscompares++; $display("FAIL reset_collision: got %b want 0", collision_err); end
        drive_idle();
        tick();
        reset = 1;
        settle(2);
    endtask

    task automatic test_mul_then_alu();
        req_valid = 1; req_is_mul = 1; #1;
        vectors++; if (req_grant !== 1'b1) begin miscompares++; $display("FAIL mul_alu_t0_grant: got %b want 1", req_grant); end
        tick(); req_valid = 0;
        tick(); req_valid = 1; req_is_mul = 0; #1;
        vectors++; if (req_grant !== 1'b0) begin miscompares++; $display("FAIL mul_alu_t2_grant: got %b want 0", req_grant); end
        tick(); #1;
        vectors++; if (req_grant !== 1'b1) begin miscompares++; $display("FAIL mul_alu_t3_grant: got %b want 1", req_grant); end
        vectors++; if (wb_owner !== 2'd2) begin miscompares++; $display("FAIL mul_alu_t3_owner: got %0d want 2", wb_owner); end
        tick(); req_valid = 0; #1;
        vectors++; if (wb_owner !== 2'd1) begin miscompares++; $display("FAIL mul_alu_t4_owner: got %0d want 1", wb_owner); end
        settle(5);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_owner;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1; req_is_mul = 0; #1;
            exp_owner = (k == 0) ? 2'd0 : 2'd1;
            vectors++; if (req_grant !== 1'b1) begin miscompares++; $display("FAIL b2b_grant[%0d]: got %b want 1", k, req_grant); end
            vectors++; if (wb_owner !== exp_owner) begin miscompares++; $display("FAIL b2b_owner[%0d]: got %0d want %0d", k, wb_owner, exp_owner); end
            tick();
        end
        req_valid = 0; #1;
        vectors++; if (wb_owner !== 2'd1) begin miscompares++; $display("FAIL b2b_last_owner: got %0d want 1", wb_owner); end
        settle(5);
    endtask

    task automatic test_starvation();
        logic exp_ready, exp_blocked, exp_grant;
        req_valid = 1; req_is_mul = 1;
        repeat (3) tick();
        div_resp_valid = 1;
        // cycles 3..10: r[0] busy with MULs until grants stop at cycle 7
        for (int c = 3; c <= 10; c++) begin
            #1;
            exp_ready   = (c == 10);
            exp_blocked = (c >= 7);
            exp_grant   = (c < 7);
            vectors++; if (div_resp_ready !== exp_ready) begin miscompares++; $display("FAIL starve_ready[%0d]: got %b want %b", c, div_resp_ready, exp_ready); end
            vectors++; if (issue_blocked !== exp_blocked) begin miscompares++; $display("FAIL starve_blocked[%0d]: got %b want %b", c, issue_blocked, exp_blocked); end
            vectors++; if (req_grant !== exp_grant) begin miscompares++; $display("FAIL starve_grant[%0d]: got %b want %b", c, req_grant, exp_grant); end
            tick();
        end
        #1;
        vectors++; if (issue_blocked !== 1'b0) begin miscompares++; $display("FAIL starve_release_blocked: got %b want 0", issue_blocked); end
        vectors++; if (req_grant !== 1'b1) begin miscompares++; $display("FAIL starve_release_grant: got %b want 1", req_grant); end
        settle(6);
    endtask

    task automatic test_mispredict_free();
        req_valid = 1; req_is_mul = 1; req_br_mask = 20'h00004;
        tick();
        drive_idle(); brupdate_mispredict_mask = 20'h00004;
        tick();
        brupdate_mispredict_mask = '0; req_valid = 1; req_is_mul = 0; #1;
        vectors++; if (req_grant !== 1'b1) begin miscompares++; $display("FAIL mispred_alu_grant: got %b want 1", req_grant); end
        tick(); req_valid = 0; #1;
        vectors++; if (wb_owner !== 2'd1) begin miscompares++; $display("FAIL mispred_owner: got %0d want 1", wb_owner); end
        settle(5);
    endtask

    task automatic test_resolve_then_mispredict();
        req_valid = 1; req_is_mul = 1; req_br_mask = 20'h00004;
        tick();
        drive_idle(); brupdate_resolve_mask = 20'h00004;
        tick();
        brupdate_resolve_mask = '0; brupdate_mispredict_mask = 20'h00004;
        req_valid = 1; req_is_mul = 0; #1;
        vectors++; if (req_grant !== 1'b0) begin miscompares++; $display("FAIL resolved_alu_grant: got %b want 0", req_grant); end
        tick(); drive_idle(); #1;
        vectors++; if (wb_owner !== 2'd2) begin miscompares++; $display("FAIL resolved_owner: got %0d want 2", wb_owner); end
        settle(5);
    endtask

    task automatic test_flush();
        req_valid = 1; req_is_mul = 1;
        repeat (3) tick();
        flush = 1; div_resp_valid = 1; #1;
        vectors++; if (req_grant !== 1'b0) begin miscompares++; $display("FAIL flush_grant: got %b want 0", req_grant); end
        vectors++; if (div_resp_ready !== 1'b0) begin miscompares++; $display("FAIL flush_div_ready: got %b want 0", div_resp_ready); end
        vectors++; if (wb_owner !== 2'd0) begin miscompares++; $display("FAIL flush_owner: got %0d want 0", wb_owner); end
        tick(); drive_idle(); #1;
        vectors++; if (wb_owner !== 2'd0) begin miscompares++; $display("FAIL post_flush_owner: got %0d want 0", wb_owner); end
        req_valid = 1; req_is_mul = 0; #1;
        vectors++; if (req_grant !== 1'b1) begin miscompares++; $display("FAIL post_flush_alu_grant: got %b want 1", req_grant); end
        settle(5);
    endtask

    task automatic test_reset_mid();
        req_valid = 1; req_is_mul = 1;
        tick(); tick();
        drive_idle(); reset = 0;
        tick();
        reset = 1; #1;
        vectors++; if (wb_owner !== 2'd0) begin miscompares++; $display("FAIL midreset_owner: got %0d want 0", wb_owner); end
        req_valid = 1; req_is_mul = 0; #1;
        vectors++; if (req_grant !== 1'b1) begin miscompares++; $display("FAIL midreset_alu_grant: got %b want 1", req_grant); end
        settle(5);
    endtask

    task automatic test_collision();
        alu_resp_valid = 1; #1;
        tick(); alu_resp_valid = 0; #1;
        vectors++; if (collision_err !== 1'b0) begin miscompares++; $display("FAIL coll_single: got %b want 0", collision_err); end
        alu_resp_valid = 1; mul_resp_valid = 1;
        tick(); alu_resp_valid = 0; mul_resp_valid = 0; #1;
        vectors++; if (collision_err !== 1'b1) begin miscompares++; $display("FAIL coll_alu_mul: got %b want 1", collision_err); end
        tick(); #1;
        vectors++; if (collision_err !== 1'b0) begin miscompares++; $display("FAIL coll_pulse_end: got %b want 0", collision_err); end
        alu_resp_valid = 1; div_resp_valid = 1;
        tick(); drive_idle(); #1;
        vectors++; if (collision_err !== 1'b1) begin miscompares++; $display("FAIL coll_alu_div: got %b want 1", collision_err); end
        settle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1;
        drive_idle();
        test_reset();
        test_mul_then_alu();
        test_back_to_back();
        test_starvation();
        test_mispredict_free();
        test_resolve_then_mispredict();
        test_flush();
        test_reset_mid();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_port_scheduler.md
Name: wb_port_scheduler

Overview:
- Issue-time scheduler for the single integer writeback port shared by the ALU (fixed latency), the pipelined multiplier (fixed latency MUL_LAT) and the iterative divider (variable latency).
- Holds a reservation shift register so that a granted ALU or MUL issue never collides at writeback.
- Arbitrates divider completions into free writeback cycles, with anti-starvation.
- Sits between the issue-slot select logic and the ALU execution unit, and replaces the post-hoc "multiple units fighting over write port" check with prevention plus a residual error flag.

Parameters:
MUL_LAT, 3, multiplier issue-to-writeback latency in cycles (>=2)
ALU_LAT, 1, ALU issue-to-writeback latency (1 <= ALU_LAT < MUL_LAT)
BR_W, 20, branch mask width
STARVE_LIM, 4, divider wait cycles before new issues are blocked

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-low
req_valid  in  1  issue candidate present this cycle
req_is_mul  in  1  1 = multiplier op, 0 = ALU op
req_br_mask  in  BR_W  branch mask of issuing uop
req_grant  out  1  issue accepted this cycle (combinational)
div_resp_valid  in  1  divider holds a completed result
div_resp_ready  out  1  divider may write back this cycle (combinational)
alu_resp_valid  in  1  ALU writeback observed
mul_resp_valid  in  1  multiplier writeback observed
brupdate_resolve_mask  in  BR_W  branches resolved this cycle
brupdate_mispredict_mask  in  BR_W  branches mispredicted this cycle
flush  in  1  pipeline flush, clears all reservations
wb_owner  out  2  predicted owner of the current writeback: 0 none, 1 ALU, 2 MUL, 3 DIV
issue_blocked  out  1  starvation block active
collision_err  out  1  registered one-cycle pulse when >1 writer observed

Behaviour:
- State:
  - r[0..MUL_LAT-1]: valid bit, owner bit (0 ALU, 1 MUL) and br_mask per slot. Slot i = writeback i cycles from now.
  - r[MUL_LAT] is implicitly empty.
  - starve counter: 0..STARVE_LIM, saturating.
- Reset (reset==0 at a clock edge): all slot valids 0, masks 0, starve counter 0, collision_err 0. Combinational outputs then evaluate to req_grant = req_valid, div_resp_ready = div_resp_valid, wb_owner = 0 or 3, issue_blocked = 0.
- Slot live: valid && !(br_mask & brupdate_mispredict_mask) && !flush, evaluated combinationally.
- req_grant = req_valid && !issue_blocked && !flush && !live(r[L]), where L = MUL_LAT if req_is_mul else ALU_LAT. MUL is therefore never blocked by reservations.
- div_resp_ready = div_resp_valid && !flush && !live(r[0]).
- wb_owner: live(r[0]) gives 1 or 2 from the owner bit; else div_resp_ready gives 3; else 0.
- Update each edge:
  - r[i] <= r[i+1] for i < MUL_LAT-1; r[MUL_LAT-1] <= empty.
  - Every carried mask is ANDed with ~brupdate_resolve_mask.
  - Killed slots are written invalid.
  - On req_grant, slot L-1 is written valid with owner = req_is_mul and mask = req_br_mask & ~resolve.
  - If req_br_mask hits the mispredict mask in the same cycle, the grant is still given but the slot is written invalid.
- flush: all slots invalid next cycle. Grants and div_resp_ready are 0 in the flush cycle. The starve counter is unaffected.
- Starvation:
  - Counter increments while div_resp_valid && !div_resp_ready.
  - Counter clears on div_resp_ready or !div_resp_valid.
  - issue_blocked = (counter == STARVE_LIM). It forces req_grant = 0 until div_resp_ready fires.
  - Worst-case divider wait is STARVE_LIM + MUL_LAT cycles.
- collision_err: registered, = popcount(alu_resp_valid, mul_resp_valid, div_resp_ready) > 1. One-cycle pulse, not sticky.
- Simultaneous resolve and mispredict on the same bit: mispredict wins (slot killed).

Test Plan:
1. MUL granted at t0 with MUL_LAT=3, ALU request at t2 -> req_grant=0 at t2. ALU at t3 -> req_grant=1. wb_owner=2 at t3 and 1 at t4.
2. Back-to-back ALU issues every cycle -> req_grant=1 every cycle. wb_owner=1 from the cycle after the first grant.
3. MUL issued every cycle with div_resp_valid held -> div_resp_ready=0 for 4 cycles, then issue_blocked=1 and req_grant=0. div_resp_ready=1 exactly 3 cycles later, after which issue_blocked=0.
4. MUL with req_br_mask=0x00004 granted, then brupdate_mispredict_mask=0x00004 one cycle later -> slot freed. An ALU request whose slot coincides is granted, and wb_owner shows 1 at that writeback.
5. Resolve of bit 2 before a mispredict of bit 2 -> the reservation survives and wb_owner=2 at the writeback.
6. flush with 3 live slots -> all grants 0 in that cycle, wb_owner=0 next cycle. Reset asserted mid-operation clears all state. Forcing alu_resp_valid=mul_resp_valid=1 -> collision_err=1 for exactly one cycle.
